// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - AC97 receive frame geometry, slot/tag indices and FSM state encoding
// Shared by ac97_rx_sync and ac97_rx_frame; no ports.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int TAG_BITS   = 16;
  localparam int SLOT_BITS  = 20;

  localparam int SLOT_CMD_ADDR = 1;
  localparam int SLOT_CMD_DATA = 2;
  localparam int SLOT_PCM_L    = 3;
  localparam int SLOT_PCM_R    = 4;

  localparam int TAG_CODEC_READY = 15;
  localparam int TAG_SLOT1_VALID = 14;
  localparam int TAG_SLOT2_VALID = 13;
  localparam int TAG_SLOT3_VALID = 12;
  localparam int TAG_SLOT4_VALID = 11;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_HUNT  = 2'd0;
  localparam rx_state_t ST_TAG   = 2'd1;
  localparam rx_state_t ST_SLOTS = 2'd2;

  // Frame bit index carrying the LSB of slot n (1..12).
  function automatic logic [7:0] slot_last_bit(input int n);
    return 8'(TAG_BITS + SLOT_BITS * n - 1);
  endfunction

endpackage

// File: rtl/ac97_rx_sync.sv
// rtl/ac97_rx_sync.sv - synchronizes AC97 inputs into clk and detects bit_clk falling edges
// Ports: clk, reset_b (async active-low); ac97_bit_clk_i, ac97_synch_i, ac97_sdata_i (async);
//        bit_event_o (one clk per bit_clk falling edge), synch_o, sdata_o (synchronized levels).
module ac97_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic ac97_bit_clk_i,
  input  logic ac97_synch_i,
  input  logic ac97_sdata_i,
  output logic bit_event_o,
  output logic synch_o,
  output logic sdata_o
);
  import ac97_pkg::*;

  logic [SYNC_STAGES-1:0] bclk_q;
  logic [SYNC_STAGES-1:0] synch_q;
  logic [SYNC_STAGES-1:0] sdata_q;
  logic                   bclk_prev_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bclk_q      <= '0;
      synch_q     <= '0;
      sdata_q     <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_q      <= (bclk_q << 1) | SYNC_STAGES'(ac97_bit_clk_i);
      synch_q     <= (synch_q << 1) | SYNC_STAGES'(ac97_synch_i);
      sdata_q     <= (sdata_q << 1) | SYNC_STAGES'(ac97_sdata_i);
      bclk_prev_q <= bclk_q[SYNC_STAGES-1];
    end
  end

  // All three inputs see the same latency, so the data levels presented with
  // the edge pulse are the ones the codec held around that falling edge.
  assign bit_event_o = bclk_prev_q & ~bclk_q[SYNC_STAGES-1];
  assign synch_o     = synch_q[SYNC_STAGES-1];
  assign sdata_o     = sdata_q[SYNC_STAGES-1];

endmodule

// File: rtl/ac97_rx_frame.sv
// rtl/ac97_rx_frame.sv - AC97 codec-to-controller frame receiver (tag, status, PCM L/R)
// Ports: clk, reset_b (async active-low); ac97_bit_clk, ac97_synch, ac97_sdata_in (codec side);
//        pcm_left/pcm_right/valid/ack (PCM handshake); tag; status_addr/status_data/status_valid;
//        bit_count, frame_count (position/progress); overrun, frame_err (sticky errors).
module ac97_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int PCM_BITS    = 18
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                ac97_bit_clk,
  input  logic                ac97_synch,
  input  logic                ac97_sdata_in,
  output logic [PCM_BITS-1:0] pcm_left,
  output logic [PCM_BITS-1:0] pcm_right,
  output logic                valid,
  input  logic                ack,
  output logic [15:0]         tag,
  output logic [6:0]          status_addr,
  output logic [15:0]         status_data,
  output logic                status_valid,
  output logic [7:0]          bit_count,
  output logic [3:0]          frame_count,
  output logic                overrun,
  output logic                frame_err
);
  import ac97_pkg::*;

  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);
  localparam logic [7:0] TAG_LAST = 8'(TAG_BITS - 1);

  logic bit_event, synch_s, sdata_s;

  ac97_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk            (clk),
    .reset_b        (reset_b),
    .ac97_bit_clk_i (ac97_bit_clk),
    .ac97_synch_i   (ac97_synch),
    .ac97_sdata_i   (ac97_sdata_in),
    .bit_event_o    (bit_event),
    .synch_o        (synch_s),
    .sdata_o        (sdata_s)
  );

  // Receive side: frame position and per-frame shadows.
  rx_state_t             state_q, state_d;
  logic [7:0]            bit_count_q, bit_count_d;
  logic                  synch_prev_q, synch_prev_d;
  logic [TAG_BITS-1:0]   tag_sh_q, tag_sh_d;
  logic [SLOT_BITS-2:0]  slot_sh_q, slot_sh_d;
  logic [6:0]            s1_q, s1_d;
  logic [15:0]           s2_q, s2_d;
  logic [PCM_BITS-1:0]   s3_q, s3_d, s4_q, s4_d;
  logic                  done_q, done_d;
  logic                  frame_err_q, frame_err_d;

  logic                  rise;
  logic [7:0]            next_pos;
  logic [SLOT_BITS-1:0]  slot_word;

  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    synch_prev_d = synch_prev_q;
    tag_sh_d     = tag_sh_q;
    slot_sh_d    = slot_sh_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    s3_d         = s3_q;
    s4_d         = s4_q;
    done_d       = 1'b0;
    frame_err_d  = frame_err_q;
    rise         = synch_s & ~synch_prev_q;
    next_pos     = bit_count_q + 8'd1;
    slot_word    = {slot_sh_q, sdata_s};

    if (bit_event) begin
      synch_prev_d = synch_s;
      if (state_q == ST_HUNT) begin
        if (rise) begin
          state_d     = ST_TAG;
          bit_count_d = 8'd0;
          tag_sh_d    = {{(TAG_BITS-1){1'b0}}, sdata_s};
        end
      end else if (rise && bit_count_q != LAST_BIT) begin
        // Early sync: drop the partial frame and treat this bit as a new tag MSB.
        frame_err_d = 1'b1;
        state_d     = ST_TAG;
        bit_count_d = 8'd0;
        tag_sh_d    = {{(TAG_BITS-1){1'b0}}, sdata_s};
      end else begin
        bit_count_d = next_pos;
        case (state_q)
          ST_TAG: begin
            tag_sh_d = {tag_sh_q[TAG_BITS-2:0], sdata_s};
            if (next_pos == TAG_LAST) state_d = ST_SLOTS;
          end
          ST_SLOTS: begin
            if (bit_count_q == LAST_BIT) begin
              // Only a sync edge on the bit after 255 chains straight into the next frame.
              bit_count_d = 8'd0;
              if (rise) begin
                state_d  = ST_TAG;
                tag_sh_d = {{(TAG_BITS-1){1'b0}}, sdata_s};
              end else begin
                state_d = ST_HUNT;
              end
            end else begin
              slot_sh_d = slot_word[SLOT_BITS-2:0];
              if (next_pos == slot_last_bit(SLOT_CMD_ADDR)) s1_d = slot_word[18:12];
              if (next_pos == slot_last_bit(SLOT_CMD_DATA)) s2_d = slot_word[19:4];
              if (next_pos == slot_last_bit(SLOT_PCM_L)) s3_d = slot_word[SLOT_BITS-1 -: PCM_BITS];
              if (next_pos == slot_last_bit(SLOT_PCM_R)) s4_d = slot_word[SLOT_BITS-1 -: PCM_BITS];
              if (next_pos == LAST_BIT) done_d = 1'b1;
            end
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end
  end

  // Consumer side: published results, updated the clk after frame completion.
  logic [15:0]         tag_q, tag_d;
  logic [PCM_BITS-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic                valid_q, valid_d, overrun_q, overrun_d;
  logic [6:0]          st_addr_q, st_addr_d;
  logic [15:0]         st_data_q, st_data_d;
  logic                st_valid_q, st_valid_d;
  logic [3:0]          frame_count_q, frame_count_d;
  logic                load_pcm, load_st;

  always_comb begin
    tag_d         = tag_q;
    pcm_l_d       = pcm_l_q;
    pcm_r_d       = pcm_r_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    st_addr_d     = st_addr_q;
    st_data_d     = st_data_q;
    st_valid_d    = 1'b0;
    frame_count_d = frame_count_q;
    load_pcm      = done_q & tag_sh_q[TAG_CODEC_READY] & tag_sh_q[TAG_SLOT3_VALID]
                    & tag_sh_q[TAG_SLOT4_VALID];
    load_st       = done_q & tag_sh_q[TAG_CODEC_READY] & tag_sh_q[TAG_SLOT1_VALID]
                    & tag_sh_q[TAG_SLOT2_VALID];

    if (done_q) begin
      tag_d         = tag_sh_q;
      frame_count_d = frame_count_q + 4'd1;
    end
    if (load_pcm) begin
      // An ack in the same clk frees the holding register for the new pair.
      if (!valid_q || ack) begin
        pcm_l_d = s3_q;
        pcm_r_d = s4_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
    if (load_st) begin
      st_valid_d = 1'b1;
      st_addr_d  = s1_q;
      st_data_d  = s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_HUNT;
      bit_count_q   <= '0;
      synch_prev_q  <= 1'b0;
      tag_sh_q      <= '0;
      slot_sh_q     <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      s4_q          <= '0;
      done_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      tag_q         <= '0;
      pcm_l_q       <= '0;
      pcm_r_q       <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      st_addr_q     <= '0;
      st_data_q     <= '0;
      st_valid_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_count_q   <= bit_count_d;
      synch_prev_q  <= synch_prev_d;
      tag_sh_q      <= tag_sh_d;
      slot_sh_q     <= slot_sh_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      s4_q          <= s4_d;
      done_q        <= done_d;
      frame_err_q   <= frame_err_d;
      tag_q         <= tag_d;
      pcm_l_q       <= pcm_l_d;
      pcm_r_q       <= pcm_r_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      st_addr_q     <= st_addr_d;
      st_data_q     <= st_data_d;
      st_valid_q    <= st_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pcm_left     = pcm_l_q;
  assign pcm_right    = pcm_r_q;
  assign valid        = valid_q;
  assign tag          = tag_q;
  assign status_addr  = st_addr_q;
  assign status_data  = st_data_q;
  assign status_valid = st_valid_q;
  assign bit_count    = bit_count_q;
  assign frame_count  = frame_count_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule
